// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// Module   : led_ctrl_pkg
// Brief    : Mode encodings, LED pattern constants and mode-step helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SLOW  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_FAST  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_CHASE = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ON    = 3'd4;

    localparam logic [3:0] LED_ALL_OFF = 4'b0000;
    localparam logic [3:0] LED_ALL_ON  = 4'b1111;
    localparam logic [3:0] CHASE_SEED  = 4'b0001;

    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
        case (m)
            MODE_OFF:   next_mode = MODE_SLOW;
            MODE_SLOW:  next_mode = MODE_FAST;
            MODE_FAST:  next_mode = MODE_CHASE;
            MODE_CHASE: next_mode = MODE_ON;
            default:    next_mode = MODE_OFF;
        endcase
    endfunction

    function automatic logic [3:0] entry_led(input logic [MODE_W-1:0] m);
        case (m)
            MODE_SLOW,
            MODE_FAST,
            MODE_ON:    entry_led = LED_ALL_ON;
            MODE_CHASE: entry_led = CHASE_SEED;
            default:    entry_led = LED_ALL_OFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchronizer, stable-level debouncer and press edge detector
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST  = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ARM_DONE = c_CNT_W'(DB_CYCLES);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_prev;
    logic               r_rise;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_armed;
    logic [c_CNT_W-1:0] r_arm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_prev    <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;

            if (r_sync2 != r_level) begin
                if (r_cnt == c_DB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            r_prev <= r_level;
            r_rise <= r_level & ~r_prev & r_armed;

            // A button held through reset must be seen released before any
            // press counts, otherwise the post-reset 0->1 would step the mode.
            if (!r_armed) begin
                if (!r_sync1 && !r_sync2) begin
                    if (r_arm_cnt == c_ARM_DONE) begin
                        r_armed <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + c_CNT_W'(1);
                    end
                end else begin
                    r_arm_cnt <= '0;
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
// ============================================================================
// Module   : led_pattern_ctrl
// Brief    : Push-button mode sequencer with blink time base and LED patterns
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_F       = 25000000,
    parameter int SLOW_CYCLES = CLK_F / 2,
    parameter int FAST_CYCLES = CLK_F / 10,
    parameter int DB_CYCLES   = CLK_F / 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    output logic [3:0]        led,
    output logic [MODE_W-1:0] mode,
    output logic              tick
);

    localparam int                  c_TCNT_W    = $clog2(SLOW_CYCLES + 1);
    localparam logic [c_TCNT_W-1:0] c_SLOW_LAST = c_TCNT_W'(SLOW_CYCLES - 1);
    localparam logic [c_TCNT_W-1:0] c_FAST_LAST = c_TCNT_W'(FAST_CYCLES - 1);

    logic [MODE_W-1:0]   r_mode;
    logic [3:0]          r_led;
    logic [c_TCNT_W-1:0] r_cnt;

    logic                w_press;
    logic                w_unused_level;
    logic                w_counting;
    logic                w_illegal;
    logic                w_tick;
    logic [c_TCNT_W-1:0] w_last;
    logic [MODE_W-1:0]   w_next_mode;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .rst   (rst),
        .din   (button),
        .level (w_unused_level),
        .rise  (w_press)
    );

    assign w_counting  = (r_mode == MODE_SLOW) || (r_mode == MODE_FAST) ||
                         (r_mode == MODE_CHASE);
    assign w_illegal   = (r_mode > MODE_ON);
    assign w_last      = (r_mode == MODE_SLOW) ? c_SLOW_LAST : c_FAST_LAST;
    assign w_tick      = w_counting && (r_cnt == w_last);
    assign w_next_mode = next_mode(r_mode);

    // Priority: illegal recovery, then press (discards a coincident tick), then tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_OFF;
            r_led  <= LED_ALL_OFF;
            r_cnt  <= '0;
        end else if (w_illegal) begin
            r_mode <= MODE_OFF;
            r_led  <= LED_ALL_OFF;
            r_cnt  <= '0;
        end else if (w_press) begin
            r_mode <= w_next_mode;
            r_led  <= entry_led(w_next_mode);
            r_cnt  <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            if (r_mode == MODE_CHASE) begin
                r_led <= {r_led[2:0], r_led[3]};
            end else begin
                r_led <= ~r_led;
            end
        end else if (w_counting) begin
            r_cnt <= r_cnt + c_TCNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign mode = r_mode;
    assign led  = r_led;
    assign tick = w_tick;

endmodule

`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Controller that sequences the board LEDs from a single push-button. It debounces the button and steps through five display modes, one step per press. It generates the blink time base for the selected mode and drives four LEDs with the mode's pattern. It sits between the raw button pin and the LED pins, in place of a free-running blinker.

Parameters:
CLK_F, 25000000, input clock frequency in Hz (documentation and default derivation only)
SLOW_CYCLES, 12500000, clock cycles per tick in SLOW mode (0.5 s at 25 MHz); must be >= FAST_CYCLES
FAST_CYCLES, 2500000, clock cycles per tick in FAST and CHASE modes (0.1 s); must be >= 2
DB_CYCLES, 500000, consecutive stable cycles needed to accept a button level (20 ms); must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
button  input  1  raw asynchronous push-button, high = pressed
led  output  4  LED drive, high = on
mode  output  3  current mode encoding
tick  output  1  one-cycle pulse at each pattern step (observability)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on posedge clk.
- Reset values, applied on the edge where rst=1:
  - mode=OFF(0), led=4'b0000, tick=0.
  - Synchronizer, debounced level, debounce counter and tick counter all cleared to 0.
- Button path:
  - button passes through a 2-FF synchronizer.
  - btn_db takes the synchronized value only after that value has differed from btn_db for DB_CYCLES consecutive cycles. Any mismatch gap restarts the debounce count.
  - press = one-cycle pulse on each 0->1 transition of btn_db. Releases produce no event.
- Latency: button sampled high at edge 0 and held -> press asserted in cycle DB_CYCLES+2 -> mode changes at edge DB_CYCLES+3.
- A held button yields exactly one press. A glitch shorter than DB_CYCLES yields none.
- Mode FSM advances one step per press and wraps:
  - OFF(0) -> SLOW(1) -> FAST(2) -> CHASE(3) -> ON(4) -> OFF(0).
  - Encodings 5-7 are illegal and recover to OFF on the next edge.
- Tick counter:
  - Period P = SLOW_CYCLES in SLOW; P = FAST_CYCLES in FAST and CHASE.
  - Counts 0..P-1. tick=1 in the cycle the count equals P-1, and the count returns to 0 on the next edge.
  - In OFF and ON the count is held at 0 and tick=0.
  - Counter width is $clog2(SLOW_CYCLES+1). Debounce width is $clog2(DB_CYCLES+1).
- LED patterns, with the mode-entry value set on the same edge mode changes:
  - OFF: 0000.
  - ON: 1111.
  - SLOW/FAST: entry 1111; all four bits invert on each edge where tick=1.
  - CHASE: entry 0001; rotate left on each tick (0001,0010,0100,1000,0001...).
- Mode entry also clears the tick counter to 0, so the first step occurs P cycles after entry.
- Simultaneous press and tick: press wins. The new mode's entry values are loaded and the tick is discarded.
- Reset mid-operation (any mode, mid-debounce, mid-count): all state returns to reset values on that edge. No press is generated by a button held through reset until btn_db sees a fresh 0->1.

Decomposition:
- Package led_ctrl_pkg holds:
  - mode encoding localparams MODE_OFF..MODE_ON and MODE_W=3;
  - pattern constants LED_ALL_OFF, LED_ALL_ON, CHASE_SEED.
- Sub-module btn_debounce(clk, rst, din, level, rise) holds the synchronizer, debounce counter and edge detector. Parameter: DB_CYCLES.
- The FSM, tick counter and LED pattern logic stay in led_pattern_ctrl.

Test Plan:
Bench parameters are SLOW_CYCLES=8, FAST_CYCLES=4, DB_CYCLES=3 unless noted.
1. Reset: rst=1 for 2 cycles with button=1 -> mode=0, led=0000, tick=0. After rst drops with button still 1 -> no mode change until button is released and pressed again.
2. Single press: button=1 from edge 0, held 30 cycles -> mode=1 and led=1111 at edge 6. Then tick every 8 cycles and led toggles 0000/1111. Exactly one mode step for the whole hold.
3. Bounce rejection: button 1 for 2 cycles, 0 for 2, 1 for 2, then 0 -> mode stays 0 and press never asserts.
4. Chase: three clean presses -> mode=3, led=0001. Then led=0010, 0100, 1000, 0001 at 4-cycle intervals, with tick coincident with each step.
5. Wrap and simultaneity: from mode 3, time a press so its pulse coincides with tick -> mode=4, led=1111, no rotation applied. A further press -> mode=0, led=0000.
6. Reset mid-CHASE at led=0100 with 2 counts into the period -> next edge mode=0, led=0000, counter=0. Forced illegal mode=6 -> OFF next edge.
